pad_input_filter: RTL and testbench

- Consumes the `pad_out_o` values of a bank of input pad cells and makes them safe for the core clock domain.
- Per pad: a 2-flop synchronizer, then a programmable counter-based debouncer, then registered rising/falling-edge pulses.
- Sits between the pad ring and GPIO/peripheral logic; its outputs are glitch-free, clock-aligned levels and single-cycle edge events.

---
 rtl/pad_input_filter_pkg.sv | 13 +
 rtl/pad_filter_bit.sv | 71 +++++++
 rtl/pad_input_filter.sv | 34 +++
 tb/tb_pad_input_filter.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/pad_input_filter_pkg.sv
// Shared types and default sizes for the pad input filter: per-pad debounce
// state encoding and the default pad count / counter width.
package pad_input_filter_pkg;

  typedef enum logic {
    FILT_STABLE,
    FILT_SETTLING
  } filt_state_e;

  localparam int PAD_FILT_CNT_W  = 16;
  localparam int PAD_FILT_NUM_IN = 4;

endpackage : pad_input_filter_pkg

// File: rtl/pad_filter_bit.sv
// One pad: 2-flop synchronizer, counter-based debouncer and registered
// rise/fall pulses that line up with the change of level_o.
module pad_filter_bit
  import pad_input_filter_pkg::*;
#(
  parameter int CNT_W = PAD_FILT_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             pad_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] thr_i,
  output logic             level_o,
  output logic             rise_o,
  output logic             fall_o
);

  logic             s1_q;
  logic             sync_q;
  logic             stable_q;
  logic             stable_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  filt_state_e      state;

  // The state is implied by the sampled pad disagreeing with the accepted level.
  assign state = (en_i && (sync_q != stable_q)) ? FILT_SETTLING : FILT_STABLE;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    stable_d = stable_q;
    cnt_d    = '0;
    if (!en_i) begin
      stable_d = sync_q;
    end else begin
      case (state)
        FILT_SETTLING: begin
          // >= rather than == so that lowering the threshold mid-count
          // accepts at once instead of waiting for a wrap that never comes.
          if (cnt_q >= thr_i) stable_d = sync_q;
          else                cnt_d    = cnt_q + CNT_W'(1);
        end
        default: cnt_d = '0;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, which is what makes s1 -> s2 a real two-stage chain.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q     <= 1'b0;
      sync_q   <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      rise_o   <= 1'b0;
      fall_o   <= 1'b0;
    end else begin
      s1_q     <= pad_i;
      sync_q   <= s1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      rise_o   <= stable_d & ~stable_q;
      fall_o   <= ~stable_d & stable_q;
    end
  end

  assign level_o = stable_q;

endmodule : pad_filter_bit

// File: rtl/pad_input_filter.sv
// Bank of independent pad filters: makes asynchronous pad levels safe for the
// core clock domain and produces single-cycle edge events per pad.
module pad_input_filter
  import pad_input_filter_pkg::*;
#(
  parameter int NUM_IN = PAD_FILT_NUM_IN,
  parameter int CNT_W  = PAD_FILT_CNT_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NUM_IN-1:0] pads_i,
  input  logic [NUM_IN-1:0] filt_en_i,
  input  logic [CNT_W-1:0]  debounce_cycles_i,
  output logic [NUM_IN-1:0] pads_o,
  output logic [NUM_IN-1:0] rise_o,
  output logic [NUM_IN-1:0] fall_o
);

  for (genvar i = 0; i < NUM_IN; i++) begin : g_pad
    pad_filter_bit #(
      .CNT_W(CNT_W)
    ) u_bit (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .pad_i  (pads_i[i]),
      .en_i   (filt_en_i[i]),
      .thr_i  (debounce_cycles_i),
      .level_o(pads_o[i]),
      .rise_o (rise_o[i]),
      .fall_o (fall_o[i])
    );
  end

endmodule : pad_input_filter

// File: tb/tb_pad_input_filter.sv
// Directed bench for pad_input_filter: bypass/debounce latency, glitch reject,
// threshold change, reset mid-count and simultaneous pads.
module tb_pad_input_filter;

  localparam int NUM_IN = 4;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NUM_IN-1:0] pads_i;
  logic [NUM_IN-1:0] filt_en_i;
  logic [CNT_W-1:0]  debounce_cycles_i;
  logic [NUM_IN-1:0] pads_o;
  logic [NUM_IN-1:0] rise_o;
  logic [NUM_IN-1:0] fall_o;

  int total = 0;
  int bad = 0;
  int both_cnt = 0;

  always #5 clk = ~clk;

  pad_input_filter #(
    .NUM_IN(NUM_IN),
    .CNT_W (CNT_W)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .pads_i           (pads_i),
    .filt_en_i        (filt_en_i),
    .debounce_cycles_i(debounce_cycles_i),
    .pads_o           (pads_o),
    .rise_o           (rise_o),
    .fall_o           (fall_o)
  );

  task automatic check(input string tag, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Observe one bit for n cycles; cycle numbers count posedges after the call.
  task automatic watch(input int b, input int n, output int fr, output int nr,
                       output int ff, output int nf);
    fr = -1; ff = -1; nr = 0; nf = 0;
    for (int k = 1; k <= n; k++) begin
      tick();
      if (rise_o[b]) begin nr++; if (fr < 0) fr = k; end
      if (fall_o[b]) begin nf++; if (ff < 0) ff = k; end
      if (rise_o[b] && fall_o[b]) both_cnt++;
    end
  endtask

  initial begin
    int fr, nr, ff, nf;
    int fr2, nr2, ff2, nf2;

    rst_n = 1'b0;
    pads_i = '0;
    filt_en_i = '0;
    debounce_cycles_i = '0;
    repeat (5) tick();
    check("reset_pads_o", pads_o, 0);
    check("reset_rise_o", rise_o, 0);
    check("reset_fall_o", fall_o, 0);
    rst_n = 1'b1;
    repeat (3) tick();

    // Bypass: 3-cycle latency, single rise pulse.
    pads_i[0] = 1'b1;
    watch(0, 10, fr, nr, ff, nf);
    check("bypass_rise_cycle", fr, 3);
    check("bypass_rise_count", nr, 1);
    check("bypass_level", pads_o[0], 1);

    // Debounce D=10: accept after 13 cycles both ways.
    filt_en_i = 4'b1110;
    debounce_cycles_i = 16'd10;
    tick();
    pads_i[1] = 1'b1;
    watch(1, 20, fr, nr, ff, nf);
    check("deb_rise_cycle", fr, 13);
    check("deb_rise_count", nr, 1);
    check("deb_level_hi", pads_o[1], 1);
    pads_i[1] = 1'b0;
    watch(1, 20, fr, nr, ff, nf);
    check("deb_fall_cycle", ff, 13);
    check("deb_fall_count", nf, 1);
    check("deb_no_rise", nr, 0);

    // Glitch of 8 cycles is rejected.
    pads_i[2] = 1'b1;
    watch(2, 8, fr, nr, ff, nf);
    pads_i[2] = 1'b0;
    watch(2, 20, fr2, nr2, ff2, nf2);
    check("glitch_no_rise", nr + nr2, 0);
    check("glitch_no_fall", nf + nf2, 0);
    check("glitch_level", pads_o[2], 0);

    // 11-cycle pulse (D+1) is accepted, then released 11 cycles later.
    pads_i[2] = 1'b1;
    watch(2, 11, fr, nr, ff, nf);
    check("pulse11_no_early_rise", nr, 0);
    pads_i[2] = 1'b0;
    watch(2, 30, fr2, nr2, ff2, nf2);
    check("pulse11_rise_cycle", fr2, 2);
    check("pulse11_fall_cycle", ff2, 13);
    check("pulse11_rise_count", nr2, 1);
    check("pulse11_fall_count", nf2, 1);

    // Threshold lowered from 100 to 20 after 50 counts: accept next cycle.
    debounce_cycles_i = 16'd100;
    tick();
    pads_i[3] = 1'b1;
    watch(3, 52, fr, nr, ff, nf);
    check("thr_no_early_rise", nr, 0);
    debounce_cycles_i = 16'd20;
    watch(3, 3, fr, nr, ff, nf);
    check("thr_lowered_rise_cycle", fr, 1);
    debounce_cycles_i = 16'd0;
    pads_i[3] = 1'b0;
    watch(3, 5, fr, nr, ff, nf);
    check("d0_fall_cycle", ff, 3);

    // Reset mid-count (D=30, cnt=15), then a full 33-cycle acceptance.
    debounce_cycles_i = 16'd30;
    tick();
    pads_i[1] = 1'b1;
    repeat (17) tick();
    check("rst_mid_pre_level", pads_o[1], 0);
    rst_n = 1'b0;
    #2;
    check("rst_mid_pads_o", pads_o, 0);
    check("rst_mid_rise_o", rise_o, 0);
    check("rst_mid_fall_o", fall_o, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    watch(1, 40, fr, nr, ff, nf);
    check("rst_release_rise_cycle", fr, 33);
    check("rst_release_rise_count", nr, 1);

    // All pads toggle together, D=0 with mixed enables: aligned rises at 3.
    pads_i = '0;
    filt_en_i = 4'b1010;
    debounce_cycles_i = 16'd0;
    repeat (10) tick();
    check("simul_pre_level", pads_o, 0);
    pads_i = 4'hF;
    for (int k = 1; k <= 6; k++) begin
      tick();
      check($sformatf("simul_rise_c%0d", k), rise_o, (k == 3) ? 4'hF : 4'h0);
      check($sformatf("simul_fall_c%0d", k), fall_o, 0);
    end
    check("simul_level", pads_o, 4'hF);

    check("rise_fall_exclusive", both_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_pad_input_filter
